// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: the op codes understood by
// the 32-bit ALU, a legality check for them, and the arbiter FSM states.
//
// Contents:
//   OP_AND .. OP_MULT  3-bit op codes driven on the ALU sel input
//   op_legal(sel)      1 when sel is one of the six op codes the ALU implements
//   estado_t           LIBRE (idle), EJECUTA (ALU driven), RESPONDE (result out)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_SUMA  = 3'b010;
    localparam logic [2:0] OP_RESTA = 3'b011;
    localparam logic [2:0] OP_MULT  = 3'b111;

    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        EJECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    // 101 and 110 have no ALU function behind them; everything else does.
    function automatic logic op_legal(input logic [2:0] sel);
        logic ok;
        case (sel)
            OP_AND, OP_OR, OP_NAND, OP_SUMA, OP_RESTA, OP_MULT: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbitro.sv
// ---------------------------------------------------------------------------
// rr_arbitro
// Purely combinational round-robin picker. Starting at index ptr and moving
// upward with wrap-around, it selects the first asserted request.
//
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  IDW    index with the highest priority this round
//   grant  out N_REQ  one-hot grant, all zero when no request is asserted
//   id     out IDW    binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbitro #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   id
);

    // Index that is i steps above ptr, wrapped into 0..N_REQ-1.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int unsigned i);
        return IDW'((32'(p) + i) % 32'(N_REQ));
    endfunction

    logic found;

    // Walk the requesters in priority order and latch onto the first hit;
    // the found flag keeps later hits from overriding it.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[wrap_idx(ptr, i)]) begin
                grant[wrap_idx(ptr, i)] = 1'b1;
                id                      = wrap_idx(ptr, i);
                found                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbitro.sv
// ---------------------------------------------------------------------------
// alu_arbitro
// Shares one combinational ALU among N_REQ requesters. A round-robin grant
// accepts one operation, the operands are registered, the ALU is driven for
// one cycle, the result is captured and returned to the winner with a
// one-cycle resp_valid pulse. One operation every three cycles.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester request
//   req_ready    one-hot grant (combinational, only in LIBRE)
//   req_a/req_b  packed operands, requester i at [i*ANCHO +: ANCHO]
//   req_sel      packed op codes, requester i at [i*3 +: 3]
//   resp_valid   one-hot response pulse to the owner of resp_dato
//   resp_dato    registered result, held until the next capture
//   resp_err     1 when the captured op code was illegal, held like resp_dato
//   ocupado      high while an operation is in flight
//   alu_*        connection to the external ALU instance
// ---------------------------------------------------------------------------
module alu_arbitro
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ANCHO = 32,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ANCHO-1:0] req_a,
    input  logic [N_REQ*ANCHO-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_sel,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [ANCHO-1:0]       resp_dato,
    output logic                   resp_err,
    output logic                   ocupado,
    output logic [ANCHO-1:0]       alu_a,
    output logic [ANCHO-1:0]       alu_b,
    output logic [2:0]             alu_sel,
    output logic                   alu_enable,
    input  logic [ANCHO-1:0]       alu_salida
);

    estado_t           estado, estado_sig;
    logic [IDW-1:0]    ptr;
    logic [ANCHO-1:0]  op_a, op_b;
    logic [2:0]        op_sel;
    logic [IDW-1:0]    op_id;
    logic [N_REQ-1:0]  grant;
    logic [IDW-1:0]    win_id;

    rr_arbitro #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (win_id)
    );

    // State register plus every datapath register. The operands are taken
    // from the winner at acceptance so later changes on req_* are ignored.
    // An illegal op never lets the ALU output through: it loads 0 and flags
    // the error instead. The pointer moves past the winner only once the
    // response has gone out, so an aborted operation does not advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= LIBRE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= 3'b000;
            op_id     <= '0;
            resp_dato <= '0;
            resp_err  <= 1'b0;
        end else begin
            estado <= estado_sig;
            case (estado)
                LIBRE: begin
                    if (|grant) begin
                        op_a   <= req_a[int'(win_id)*ANCHO +: ANCHO];
                        op_b   <= req_b[int'(win_id)*ANCHO +: ANCHO];
                        op_sel <= req_sel[int'(win_id)*3 +: 3];
                        op_id  <= win_id;
                    end
                end
                EJECUTA: begin
                    if (op_legal(op_sel)) begin
                        resp_dato <= alu_salida;
                        resp_err  <= 1'b0;
                    end else begin
                        resp_dato <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                RESPONDE: begin
                    ptr <= (op_id == IDW'(N_REQ - 1)) ? '0 : op_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and all FSM-driven outputs. Everything defaults to idle
    // values so only the active state needs to raise its own outputs.
    always_comb begin
        estado_sig = estado;
        req_ready  = '0;
        resp_valid = '0;
        alu_enable = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = 3'b000;
        case (estado)
            LIBRE: begin
                req_ready = grant;
                if (|grant) estado_sig = EJECUTA;
            end
            EJECUTA: begin
                alu_enable = 1'b1;
                alu_a      = op_a;
                alu_b      = op_b;
                alu_sel    = op_sel;
                estado_sig = RESPONDE;
            end
            RESPONDE: begin
                resp_valid[op_id] = 1'b1;
                estado_sig        = LIBRE;
            end
            default: estado_sig = LIBRE;
        endcase
    end

    assign ocupado = (estado != LIBRE);

endmodule

// File: tb/tb_alu_arbitro.sv
// ---------------------------------------------------------------------------
// tb_alu_arbitro
// Bench for alu_arbitro. Provides a behavioural ALU on the alu_* port, keeps a
// transaction-level model of the arbiter, compares every output against it on
// each falling edge, and runs directed operations with literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_arbitro;

    localparam int N_REQ = 4;
    localparam int ANCHO = 32;
    localparam int IDW   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*ANCHO-1:0] req_a = '0;
    logic [N_REQ*ANCHO-1:0] req_b = '0;
    logic [N_REQ*3-1:0]     req_sel = '0;
    logic [N_REQ-1:0]       resp_valid;
    logic [ANCHO-1:0]       resp_dato;
    logic                   resp_err;
    logic                   ocupado;
    logic [ANCHO-1:0]       alu_a, alu_b, alu_salida;
    logic [2:0]             alu_sel;
    logic                   alu_enable;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    alu_arbitro #(.N_REQ(N_REQ), .ANCHO(ANCHO), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_dato  (resp_dato),
        .resp_err   (resp_err),
        .ocupado    (ocupado),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_enable (alu_enable),
        .alu_salida (alu_salida)
    );

    // Reference result of an operation: {illegal, value}.
    function automatic logic [32:0] opRef(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            3'b000:  return {1'b0, a & b};
            3'b001:  return {1'b0, a | b};
            3'b100:  return {1'b0, ~(a & b)};
            3'b010:  return {1'b0, a + b};
            3'b011:  return {1'b0, a - b};
            3'b111:  return {1'b0, a * b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // First valid requester at or above p, wrapping; -1 when none.
    function automatic int rrPick(input logic [N_REQ-1:0] v, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    // External ALU: garbage when not enabled or on an illegal code, so the
    // block must filter both.
    logic [32:0] aluRes;
    assign aluRes     = opRef(alu_sel, alu_a, alu_b);
    assign alu_salida = !alu_enable ? 32'hA5A5_A5A5 : (aluRes[32] ? 32'hDEAD_BEEF : aluRes[31:0]);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one operation in flight, lifetime of three edges.
    bit          hasTxn = 1'b0;
    int          phase = 0;
    int          txnId = 0;
    logic [31:0] txnA = '0, txnB = '0;
    logic [2:0]  txnSel = '0;
    int          mPtr = 0;
    logic [31:0] lastDato = '0;
    logic        lastErr = 1'b0;
    int          mG;
    logic [32:0] mR;

    always @(posedge clk) begin
        if (rst) begin
            hasTxn   = 1'b0;
            mPtr     = 0;
            lastDato = '0;
            lastErr  = 1'b0;
        end else if (hasTxn) begin
            if (phase == 0) begin
                mR       = opRef(txnSel, txnA, txnB);
                lastDato = mR[31:0];
                lastErr  = mR[32];
                phase    = 1;
            end else begin
                hasTxn = 1'b0;
                mPtr   = (txnId + 1) % N_REQ;
            end
        end else begin
            mG = rrPick(req_valid, mPtr);
            if (mG >= 0) begin
                hasTxn = 1'b1;
                phase  = 0;
                txnId  = mG;
                txnA   = req_a[mG*ANCHO +: ANCHO];
                txnB   = req_b[mG*ANCHO +: ANCHO];
                txnSel = req_sel[mG*3 +: 3];
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model.
    logic [N_REQ-1:0] expReady, expRv;
    logic [31:0]      expA, expB;
    logic [2:0]       expSel;
    logic             expEn;
    int               cG;

    always @(negedge clk) begin
        if (checkEn) begin
            expReady = '0;
            expRv    = '0;
            expA     = '0;
            expB     = '0;
            expSel   = 3'b000;
            expEn    = 1'b0;
            if (!hasTxn) begin
                cG = rrPick(req_valid, mPtr);
                if (cG >= 0) expReady[cG] = 1'b1;
            end else if (phase == 0) begin
                expEn  = 1'b1;
                expA   = txnA;
                expB   = txnB;
                expSel = txnSel;
            end else begin
                expRv[txnId] = 1'b1;
            end
            checkOutput("req_ready",  64'(req_ready),  64'(expReady));
            checkOutput("resp_valid", 64'(resp_valid), 64'(expRv));
            checkOutput("resp_dato",  64'(resp_dato),  64'(lastDato));
            checkOutput("resp_err",   64'(resp_err),   64'(lastErr));
            checkOutput("ocupado",    64'(ocupado),    64'(hasTxn));
            checkOutput("alu_enable", 64'(alu_enable), 64'(expEn));
            checkOutput("alu_a",      64'(alu_a),      64'(expA));
            checkOutput("alu_b",      64'(alu_b),      64'(expB));
            checkOutput("alu_sel",    64'(alu_sel),    64'(expSel));
        end
    end

    task automatic applyStimulus(input int idx, input bit v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] sel);
        req_valid[idx]           = v;
        req_a[idx*ANCHO +: ANCHO] = a;
        req_b[idx*ANCHO +: ANCHO] = b;
        req_sel[idx*3 +: 3]       = sel;
    endtask

    task automatic waitReady(input int idx, input string name);
        int n = 0;
        @(negedge clk);
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " grant"}, 64'(req_ready[idx]), 64'd1);
    endtask

    task automatic waitResp(input int idx, input logic [31:0] expDato, input logic expErr, input string name);
        int n = 0;
        @(negedge clk);
        while (resp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " resp_valid"}, 64'(resp_valid), 64'(1) << idx);
        checkOutput({name, " resp_dato"},  64'(resp_dato),  64'(expDato));
        checkOutput({name, " resp_err"},   64'(resp_err),   64'(expErr));
    endtask

    task automatic doOp(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input logic [31:0] expDato, input logic expErr, input string name);
        applyStimulus(idx, 1'b1, a, b, sel);
        waitReady(idx, name);
        @(posedge clk); #2;
        req_valid[idx] = 1'b0;
        waitResp(idx, expDato, expErr, name);
        @(posedge clk); #2;
    endtask

    int order[5];
    int nG, nW;

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset req_ready",  64'(req_ready),  64'd0);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset ocupado",    64'(ocupado),    64'd0);
        checkOutput("reset alu_enable", 64'(alu_enable), 64'd0);
        checkOutput("reset resp_dato",  64'(resp_dato),  64'd0);
        checkOutput("reset resp_err",   64'(resp_err),   64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single request on requester 2: 7 + 5
        @(posedge clk); #2;
        applyStimulus(2, 1'b1, 32'd7, 32'd5, 3'b010);
        @(negedge clk);
        checkOutput("single ready", 64'(req_ready), 64'h4);
        @(posedge clk); #2;
        req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("single alu_enable", 64'(alu_enable), 64'd1);
        checkOutput("single alu_a",      64'(alu_a),      64'd7);
        waitResp(2, 32'd12, 1'b0, "single");
        @(posedge clk); #2;

        // Round robin from a fresh pointer: expect 0,1,2,3,0
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            applyStimulus(i, 1'b1, 32'h11 * (i + 1), 32'h1000 << i, 3'b001);
        nG = 0;
        nW = 0;
        while (nG < 5 && nW < 60) begin
            @(negedge clk);
            nW++;
            if (req_ready != '0) begin
                for (int j = 0; j < N_REQ; j++)
                    if (req_ready[j]) order[nG] = j;
                nG++;
            end
        end
        checkOutput("rr grant count", 64'(nG), 64'd5);
        @(posedge clk); #2;
        req_valid = '0;
        waitResp(0, 32'h0000_1011, 1'b0, "rr tail");
        @(posedge clk); #2;
        checkOutput("rr order0", 64'(order[0]), 64'd0);
        checkOutput("rr order1", 64'(order[1]), 64'd1);
        checkOutput("rr order2", 64'(order[2]), 64'd2);
        checkOutput("rr order3", 64'(order[3]), 64'd3);
        checkOutput("rr order4", 64'(order[4]), 64'd0);

        // Wrap, multiplication, logic ops, illegal codes
        doOp(0, 32'hFFFF_FFFF, 32'd1,       3'b010, 32'h0,         1'b0, "suma wrap");
        doOp(0, 32'h0001_0000, 32'h0001_0000, 3'b111, 32'h0,       1'b0, "mult low");
        doOp(1, 32'd3,         32'd5,       3'b011, 32'hFFFF_FFFE, 1'b0, "resta neg");
        doOp(3, 32'h0000_F0F0, 32'h0000_FF00, 3'b000, 32'h0000_F000, 1'b0, "and");
        doOp(3, 32'h0000_F0F0, 32'h0000_FF00, 3'b100, 32'hFFFF_0FFF, 1'b0, "nand");
        doOp(2, 32'd1,         32'd2,       3'b101, 32'h0,         1'b1, "illegal 101");
        doOp(1, 32'd1,         32'd2,       3'b110, 32'h0,         1'b1, "illegal 110");
        doOp(2, 32'd6,         32'd7,       3'b111, 32'd42,        1'b0, "mult 42");

        // Reset while EJECUTA aborts the operation and clears the pointer
        applyStimulus(2, 1'b1, 32'd9, 32'd9, 3'b010);
        waitReady(2, "abort");
        @(posedge clk); #2;
        req_valid[2] = 1'b0;
        checkOutput("abort in exec", 64'(alu_enable), 64'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        checkOutput("abort resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("abort ocupado",    64'(ocupado),    64'd0);
        checkOutput("abort alu_enable", 64'(alu_enable), 64'd0);
        checkOutput("abort resp_dato",  64'(resp_dato),  64'd0);
        checkOutput("abort resp_err",   64'(resp_err),   64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort no resp", 64'(resp_valid), 64'd0);
        end
        @(posedge clk); #2;
        applyStimulus(1, 1'b1, 32'd5, 32'd3, 3'b011);
        applyStimulus(3, 1'b1, 32'd4, 32'd5, 3'b111);
        @(negedge clk);
        checkOutput("post-abort ptr", 64'(req_ready), 64'h2);
        @(posedge clk); #2;
        req_valid[1] = 1'b0;
        waitResp(1, 32'd2, 1'b0, "post-abort 1");
        waitReady(3, "post-abort 3");
        @(posedge clk); #2;
        req_valid[3] = 1'b0;
        waitResp(3, 32'd20, 1'b0, "post-abort 3");
        @(posedge clk); #2;

        // Operand change after acceptance is ignored
        applyStimulus(0, 1'b1, 32'd10, 32'd20, 3'b010);
        waitReady(0, "stable");
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        req_a[0 +: ANCHO] = 32'd999;
        waitResp(0, 32'd30, 1'b0, "stable");
        @(posedge clk); #2;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
